// File: rtl/bsg_wormhole_network_test_node_master.sv
// Wormhole loopback test initiator.
// Injects num_packets_p packets (header + len body flits) toward a loopback
// client and checks the echoed flits in order. The client rewrites the cord
// field of every returned flit to my_cord_i, so returned flits are compared
// against the expected flit with its cord field replaced by my_cord_i.
// Link layout (MSB first): {v, data[flit_width_p], ready_and_rev}.
// Flit layout (LSB first): cord, len, data.
module bsg_wormhole_network_test_node_master #(
    parameter int flit_width_p  = 32,
    parameter int cord_width_p  = 4,
    parameter int len_width_p   = 4,
    parameter int num_packets_p = 16,
    parameter int max_len_p     = 3
) (
    input  logic                                 clk_i,
    input  logic                                 reset_n_i,
    input  logic                                 en_i,
    input  logic [cord_width_p-1:0]              dest_cord_i,
    input  logic [cord_width_p-1:0]              my_cord_i,
    input  logic [flit_width_p+1:0]              link_i,
    output logic [flit_width_p+1:0]              link_o,
    output logic [$clog2(num_packets_p+1)-1:0]   sent_count_o,
    output logic [$clog2(num_packets_p+1)-1:0]   recv_count_o,
    output logic                                 error_o,
    output logic                                 done_o
);

    localparam int count_w_lp = $clog2(num_packets_p + 1);
    localparam int data_w_lp  = flit_width_p - cord_width_p - len_width_p;
    localparam int len_mod_lp = max_len_p + 1;

    typedef logic [count_w_lp-1:0]   count_t;
    typedef logic [len_width_p-1:0]  len_t;
    typedef logic [data_w_lp-1:0]    data_t;
    typedef logic [flit_width_p-1:0] flit_t;

    typedef enum logic [1:0] {TX_IDLE, TX_HDR, TX_BODY, TX_DONE} tx_state_e;
    typedef enum logic       {RX_HDR, RX_BODY}                   rx_state_e;

    // Body length of packet k cycles through 0..max_len_p.
    function automatic len_t pkt_len(input count_t k);
        return len_t'(32'(k) % 32'(len_mod_lp));
    endfunction

    // Header flit of packet k addressed to cord.
    function automatic flit_t header_flit(input count_t k, input logic [cord_width_p-1:0] cord);
        flit_t f;
        f = '0;
        f[cord_width_p-1:0]                      = cord;
        f[cord_width_p +: len_width_p]           = pkt_len(k);
        f[cord_width_p+len_width_p +: data_w_lp] = data_t'(k);
        return f;
    endfunction

    // Body flit j of packet k: the whole flit is (k << 8) | j.
    function automatic flit_t body_flit(input count_t k, input len_t j);
        return flit_t'((32'(k) << 8) | 32'(j));
    endfunction

    // ---------------------------------------------------------------------
    // TX side
    // ---------------------------------------------------------------------
    tx_state_e tx_state_r, tx_state_n;
    count_t    tx_pkt_r, tx_pkt_n;
    len_t      tx_idx_r, tx_idx_n;
    len_t      tx_len;
    logic      tx_v;
    flit_t     tx_data;
    logic      tx_hs;
    logic      tx_tail;

    assign tx_len = pkt_len(tx_pkt_r);
    assign tx_v   = (tx_state_r == TX_HDR) || (tx_state_r == TX_BODY);
    assign tx_hs  = tx_v && link_i[0];

    // Outgoing flit is a pure function of state and counters, so it is stable until accepted.
    always_comb begin
        tx_data = (tx_state_r == TX_HDR) ? header_flit(tx_pkt_r, dest_cord_i)
                                         : body_flit(tx_pkt_r, tx_idx_r);
    end

    // TX next-state logic: header, then body flits, then one idle cycle before the next packet.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        tx_state_n = tx_state_r;
        tx_pkt_n   = tx_pkt_r;
        tx_idx_n   = tx_idx_r;
        tx_tail    = 1'b0;
        case (tx_state_r)
            TX_IDLE: begin
                if (en_i && (tx_pkt_r < count_t'(num_packets_p))) begin
                    tx_state_n = TX_HDR;
                end
            end
            TX_HDR: begin
                if (tx_hs) begin
                    if (tx_len != '0) begin
                        tx_state_n = TX_BODY;
                        tx_idx_n   = len_t'(1);
                    end else begin
                        tx_tail = 1'b1;
                    end
                end
            end
            TX_BODY: begin
                if (tx_hs) begin
                    if (tx_idx_r == tx_len) begin
                        tx_tail = 1'b1;
                    end else begin
                        tx_idx_n = tx_idx_r + len_t'(1);
                    end
                end
            end
            TX_DONE: begin
                tx_state_n = TX_DONE;
            end
            default: begin
                tx_state_n = TX_IDLE;
            end
        endcase
        if (tx_tail) begin
            tx_pkt_n   = (tx_pkt_r == count_t'(num_packets_p)) ? tx_pkt_r : tx_pkt_r + count_t'(1);
            tx_state_n = (tx_pkt_r == count_t'(num_packets_p - 1)) ? TX_DONE : TX_IDLE;
        end
    end

    // TX state register.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!reset_n_i) begin
            tx_state_r <= TX_IDLE;
            tx_pkt_r   <= '0;
            tx_idx_r   <= '0;
        end else begin
            tx_state_r <= tx_state_n;
            tx_pkt_r   <= tx_pkt_n;
            tx_idx_r   <= tx_idx_n;
        end
    end

    // ---------------------------------------------------------------------
    // RX side
    // ---------------------------------------------------------------------
    rx_state_e rx_state_r, rx_state_n;
    count_t    rx_pkt_r, rx_pkt_n;
    len_t      rx_idx_r, rx_idx_n;
    logic      error_r, error_n;
    logic      ready_r;
    logic      rx_v;
    flit_t     rx_flit;
    len_t      rx_exp_len;
    logic      rx_done;
    flit_t     rx_exp_flit;
    logic      rx_mismatch;
    logic      rx_tail;

    assign rx_v       = link_i[flit_width_p+1];
    assign rx_flit    = link_i[flit_width_p:1];
    assign rx_exp_len = pkt_len(rx_pkt_r);
    assign rx_done    = (rx_pkt_r == count_t'(num_packets_p));

    // Expected returned flit; the client always rewrites the cord field to our own coordinate.
    always_comb begin
        rx_exp_flit = header_flit(rx_pkt_r, my_cord_i);
        if (rx_state_r == RX_BODY) begin
            rx_exp_flit                     = body_flit(rx_pkt_r, rx_idx_r);
            rx_exp_flit[cord_width_p-1:0]   = my_cord_i;
        end
    end

    // RX next-state logic: expected length comes from the packet id, never from the flit.
    always_comb begin
        rx_state_n  = rx_state_r;
        rx_pkt_n    = rx_pkt_r;
        rx_idx_n    = rx_idx_r;
        rx_mismatch = 1'b0;
        rx_tail     = 1'b0;
        if (rx_v) begin
            case (rx_state_r)
                RX_HDR: begin
                    if (rx_done) begin
                        rx_mismatch = 1'b1;
                    end else begin
                        rx_mismatch = (rx_flit != rx_exp_flit);
                        if (rx_exp_len == '0) begin
                            rx_tail = 1'b1;
                        end else begin
                            rx_state_n = RX_BODY;
                            rx_idx_n   = len_t'(1);
                        end
                    end
                end
                RX_BODY: begin
                    rx_mismatch = (rx_flit != rx_exp_flit);
                    if (rx_idx_r == rx_exp_len) begin
                        rx_tail = 1'b1;
                    end else begin
                        rx_idx_n = rx_idx_r + len_t'(1);
                    end
                end
                default: begin
                    rx_state_n = RX_HDR;
                end
            endcase
        end
        if (rx_tail) begin
            rx_state_n = RX_HDR;
            rx_pkt_n   = rx_done ? rx_pkt_r : rx_pkt_r + count_t'(1);
        end
        error_n = error_r | rx_mismatch;
    end

    // RX state register, sticky error flag, and always-ready flop released after reset.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            rx_state_r <= RX_HDR;
            rx_pkt_r   <= '0;
            rx_idx_r   <= '0;
            error_r    <= 1'b0;
            ready_r    <= 1'b0;
        end else begin
            rx_state_r <= rx_state_n;
            rx_pkt_r   <= rx_pkt_n;
            rx_idx_r   <= rx_idx_n;
            error_r    <= error_n;
            ready_r    <= 1'b1;
        end
    end

    // ---------------------------------------------------------------------
    // Outputs
    // ---------------------------------------------------------------------
    assign link_o       = {tx_v, tx_data, ready_r};
    assign sent_count_o = tx_pkt_r;
    assign recv_count_o = rx_pkt_r;
    assign error_o      = error_r;
    assign done_o       = rx_done;

endmodule

// File: tb/tb_bsg_wormhole_network_test_node_master.sv
// Directed bench for the wormhole loopback test master. Two instances: a
// single zero-length-packet node and a 16-packet node with body lengths 0..3.
// Each is closed by a behavioural loopback client that echoes accepted flits
// one cycle later with the cord field rewritten to MY.
module tb_bsg_wormhole_network_test_node_master;

    localparam int W  = 32;
    localparam int CW = 4;
    localparam int LW = 4;
    localparam logic [CW-1:0] DEST = 4'h3;
    localparam logic [CW-1:0] MY   = 4'h5;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic dut_en = 1'b0;
    logic one_en = 1'b0;
    logic dut_ready = 1'b1;
    logic corrupt = 1'b0;

    logic         dut_rx_v = 1'b0;
    logic [W-1:0] dut_rx_data = '0;
    logic         one_rx_v = 1'b0;
    logic [W-1:0] one_rx_data = '0;

    logic [W+1:0] dut_link_i, dut_link_o, one_link_i, one_link_o;
    logic [4:0]   dut_sent, dut_recv;
    logic         dut_err, dut_done;
    logic [0:0]   one_sent, one_recv;
    logic         one_err, one_done;

    logic         dut_v, dut_rr, one_v, one_rr;
    logic [W-1:0] dut_data;

    logic [W-1:0] lb_q[$];
    logic [W-1:0] cap_q[$];
    logic [W-1:0] lb1_q[$];
    logic [W-1:0] cap1_q[$];
    logic [W-1:0] exp_q[$];

    int n_cmp = 0;
    int n_bad = 0;

    assign dut_link_i = {dut_rx_v, dut_rx_data, dut_ready};
    assign one_link_i = {one_rx_v, one_rx_data, 1'b1};
    assign dut_v      = dut_link_o[W+1];
    assign dut_data   = dut_link_o[W:1];
    assign dut_rr     = dut_link_o[0];
    assign one_v      = one_link_o[W+1];
    assign one_rr     = one_link_o[0];

    bsg_wormhole_network_test_node_master #(
        .flit_width_p(W), .cord_width_p(CW), .len_width_p(LW),
        .num_packets_p(16), .max_len_p(3)
    ) u_dut (
        .clk_i(clk), .reset_n_i(rst_n), .en_i(dut_en),
        .dest_cord_i(DEST), .my_cord_i(MY),
        .link_i(dut_link_i), .link_o(dut_link_o),
        .sent_count_o(dut_sent), .recv_count_o(dut_recv),
        .error_o(dut_err), .done_o(dut_done)
    );

    bsg_wormhole_network_test_node_master #(
        .flit_width_p(W), .cord_width_p(CW), .len_width_p(LW),
        .num_packets_p(1), .max_len_p(0)
    ) u_one (
        .clk_i(clk), .reset_n_i(rst_n), .en_i(one_en),
        .dest_cord_i(DEST), .my_cord_i(MY),
        .link_i(one_link_i), .link_o(one_link_o),
        .sent_count_o(one_sent), .recv_count_o(one_recv),
        .error_o(one_err), .done_o(one_done)
    );

    always #5 clk = ~clk;

    // Loopback client transform: rewrite cord, optionally flip bit 12 of packet 2 body flit 1.
    function automatic logic [W-1:0] lb_xform(input logic [W-1:0] f, input logic corrupt_en);
        logic [W-1:0] g;
        g = f;
        if (corrupt_en && f == 32'h0000_0201) g[12] = ~g[12];
        g[CW-1:0] = MY;
        return g;
    endfunction

    // Reference model of the flit stream: header k<<8 | len<<4 | DEST, body k<<8 | j.
    function automatic void build_exp(input int npk, input int max_len);
        exp_q.delete();
        for (int k = 0; k < npk; k++) begin
            exp_q.push_back((32'(k) << 8) | (32'(k % (max_len + 1)) << 4) | 32'(DEST));
            for (int j = 1; j <= k % (max_len + 1); j++) exp_q.push_back((32'(k) << 8) | 32'(j));
        end
    endfunction

    // Loopback for the 16-packet node; also records every injected flit.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lb_q.delete();
            cap_q.delete();
            dut_rx_v    <= 1'b0;
            dut_rx_data <= '0;
        end else begin
            if (dut_v && dut_ready) begin
                cap_q.push_back(dut_data);
                lb_q.push_back(lb_xform(dut_data, corrupt));
            end
            if (lb_q.size() > 0) begin
                dut_rx_v    <= 1'b1;
                dut_rx_data <= lb_q.pop_front();
            end else begin
                dut_rx_v <= 1'b0;
            end
        end
    end

    // Loopback for the single-packet node (always ready).
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lb1_q.delete();
            cap1_q.delete();
            one_rx_v    <= 1'b0;
            one_rx_data <= '0;
        end else begin
            if (one_v) begin
                cap1_q.push_back(one_link_o[W:1]);
                lb1_q.push_back(lb_xform(one_link_o[W:1], 1'b0));
            end
            if (lb1_q.size() > 0) begin
                one_rx_v    <= 1'b1;
                one_rx_data <= lb1_q.pop_front();
            end else begin
                one_rx_v <= 1'b0;
            end
        end
    end

    task automatic do_reset;
        @(negedge clk);
        rst_n = 1'b0; dut_en = 1'b0; one_en = 1'b0; corrupt = 1'b0; dut_ready = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic wait_dut_flit(input logic [W-1:0] want, input string name);
        int i;
        for (i = 0; i < 300; i++) begin
            @(negedge clk);
            if (dut_v && dut_data == want) break;
        end
        n_cmp++;
        if (i == 300) begin n_bad++; $display("FAIL %s: timeout waiting for flit %h", name, want); end
    endtask

    task automatic wait_dut_done(input string name);
        int i;
        for (i = 0; i < 600; i++) begin
            @(negedge clk);
            if (dut_done) break;
        end
        n_cmp++;
        if (i == 600) begin n_bad++; $display("FAIL %s: timeout waiting for done, recv=%0d", name, dut_recv); end
    endtask

    task automatic test_reset;
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if (dut_v !== 1'b0)       begin n_bad++; $display("FAIL reset_v: got %b want 0", dut_v); end
        n_cmp++; if (dut_rr !== 1'b0)      begin n_bad++; $display("FAIL reset_ready: got %b want 0", dut_rr); end
        n_cmp++; if (dut_sent !== 5'd0)    begin n_bad++; $display("FAIL reset_sent: got %0d want 0", dut_sent); end
        n_cmp++; if (dut_recv !== 5'd0)    begin n_bad++; $display("FAIL reset_recv: got %0d want 0", dut_recv); end
        n_cmp++; if (dut_err !== 1'b0)     begin n_bad++; $display("FAIL reset_err: got %b want 0", dut_err); end
        n_cmp++; if (dut_done !== 1'b0)    begin n_bad++; $display("FAIL reset_done: got %b want 0", dut_done); end
        n_cmp++; if (one_done !== 1'b0)    begin n_bad++; $display("FAIL reset_one_done: got %b want 0", one_done); end
        n_cmp++; if (one_rr !== 1'b0)      begin n_bad++; $display("FAIL reset_one_ready: got %b want 0", one_rr); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++; if (dut_rr !== 1'b1)      begin n_bad++; $display("FAIL post_reset_ready: got %b want 1", dut_rr); end
        n_cmp++; if (dut_v !== 1'b0)       begin n_bad++; $display("FAIL post_reset_idle_v: got %b want 0", dut_v); end
    endtask

    task automatic test_single_packet;
        int i;
        one_en = 1'b1;
        for (i = 0; i < 50; i++) begin
            @(negedge clk);
            if (one_done) break;
        end
        n_cmp++; if (i == 50)               begin n_bad++; $display("FAIL single_timeout: recv=%0d", one_recv); end
        n_cmp++; if (one_sent !== 1'b1)     begin n_bad++; $display("FAIL single_sent: got %0d want 1", one_sent); end
        n_cmp++; if (one_recv !== 1'b1)     begin n_bad++; $display("FAIL single_recv: got %0d want 1", one_recv); end
        n_cmp++; if (one_err !== 1'b0)      begin n_bad++; $display("FAIL single_err: got %b want 0", one_err); end
        n_cmp++; if (cap1_q.size() != 1)    begin n_bad++; $display("FAIL single_nflits: got %0d want 1", cap1_q.size()); end
        else begin
            n_cmp++; if (cap1_q[0] !== 32'h0000_0003) begin n_bad++; $display("FAIL single_hdr: got %h want 00000003", cap1_q[0]); end
        end
        repeat (5) @(negedge clk);
        n_cmp++; if (one_v !== 1'b0)        begin n_bad++; $display("FAIL single_done_hold_v: got %b want 0", one_v); end
        one_en = 1'b0;
    endtask

    task automatic test_mid_packet_reset;
        do_reset();
        dut_en = 1'b1;
        wait_dut_flit(32'h0000_0301, "midrst_wait_body");
        rst_n = 1'b0;
        #1;
        n_cmp++; if (dut_v !== 1'b0)    begin n_bad++; $display("FAIL midrst_v: got %b want 0", dut_v); end
        n_cmp++; if (dut_sent !== 5'd0) begin n_bad++; $display("FAIL midrst_sent: got %0d want 0", dut_sent); end
        n_cmp++; if (dut_recv !== 5'd0) begin n_bad++; $display("FAIL midrst_recv: got %0d want 0", dut_recv); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        n_cmp++; if (cap_q.size() == 0) begin n_bad++; $display("FAIL midrst_restart: got 0 flits want >0"); end
        else begin
            n_cmp++; if (cap_q[0] !== 32'h0000_0003) begin n_bad++; $display("FAIL midrst_first_hdr: got %h want 00000003", cap_q[0]); end
        end
        wait_dut_done("midrst_run");
        n_cmp++; if (dut_err !== 1'b0)  begin n_bad++; $display("FAIL midrst_err: got %b want 0", dut_err); end
    endtask

    task automatic test_backpressure;
        logic         pv, pr;
        logic [W-1:0] pd;
        int           c;
        do_reset();
        pv = 1'b0; pr = 1'b1; pd = '0;
        dut_en = 1'b1;
        for (c = 0; c < 400; c++) begin
            @(negedge clk);
            if (pv && !pr) begin
                n_cmp++;
                if (dut_v !== 1'b1 || dut_data !== pd) begin
                    n_bad++; $display("FAIL bp_hold: got v=%b data=%h want v=1 data=%h", dut_v, dut_data, pd);
                end
            end
            if (dut_sent == 5'd4) dut_en = 1'b0;
            if (dut_sent == 5'd4 && dut_recv == 5'd4) break;
            dut_ready = ~dut_ready;
            pv = dut_v; pr = dut_ready; pd = dut_data;
        end
        dut_ready = 1'b1;
        n_cmp++; if (c == 400)             begin n_bad++; $display("FAIL bp_timeout: sent=%0d recv=%0d", dut_sent, dut_recv); end
        repeat (5) @(negedge clk);
        n_cmp++; if (dut_sent !== 5'd4)    begin n_bad++; $display("FAIL bp_sent: got %0d want 4", dut_sent); end
        n_cmp++; if (dut_recv !== 5'd4)    begin n_bad++; $display("FAIL bp_recv: got %0d want 4", dut_recv); end
        n_cmp++; if (dut_err !== 1'b0)     begin n_bad++; $display("FAIL bp_err: got %b want 0", dut_err); end
        n_cmp++; if (dut_done !== 1'b0)    begin n_bad++; $display("FAIL bp_done: got %b want 0", dut_done); end
        build_exp(4, 3);
        n_cmp++; if (cap_q.size() != 10)   begin n_bad++; $display("FAIL bp_nflits: got %0d want 10", cap_q.size()); end
        for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
            n_cmp++;
            if (cap_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL bp_flit%0d: got %h want %h", i, cap_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_en_low;
        int i;
        do_reset();
        dut_en = 1'b1;
        wait_dut_flit(32'h0000_0101, "enlow_wait_body");
        dut_en = 1'b0;
        repeat (20) @(negedge clk);
        n_cmp++; if (dut_sent !== 5'd2) begin n_bad++; $display("FAIL enlow_sent: got %0d want 2", dut_sent); end
        n_cmp++; if (dut_recv !== 5'd2) begin n_bad++; $display("FAIL enlow_recv: got %0d want 2", dut_recv); end
        n_cmp++; if (dut_v !== 1'b0)    begin n_bad++; $display("FAIL enlow_v: got %b want 0", dut_v); end
        dut_en = 1'b1;
        for (i = 0; i < 5; i++) begin
            @(negedge clk);
            if (dut_v) break;
        end
        n_cmp++; if (dut_data !== 32'h0000_0223 || dut_v !== 1'b1) begin
            n_bad++; $display("FAIL enlow_resume_hdr: got v=%b data=%h want v=1 data=00000223", dut_v, dut_data);
        end
    endtask

    task automatic test_full_run;
        wait_dut_done("full_run");
        n_cmp++; if (dut_recv !== 5'd16) begin n_bad++; $display("FAIL full_recv: got %0d want 16", dut_recv); end
        n_cmp++; if (dut_sent !== 5'd16) begin n_bad++; $display("FAIL full_sent: got %0d want 16", dut_sent); end
        n_cmp++; if (dut_err !== 1'b0)   begin n_bad++; $display("FAIL full_err: got %b want 0", dut_err); end
        build_exp(16, 3);
        n_cmp++; if (cap_q.size() != 40) begin n_bad++; $display("FAIL full_nflits: got %0d want 40", cap_q.size()); end
        for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
            n_cmp++;
            if (cap_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL full_flit%0d: got %h want %h", i, cap_q[i], exp_q[i]); end
        end
        repeat (10) @(negedge clk);
        n_cmp++; if (dut_v !== 1'b0)     begin n_bad++; $display("FAIL full_done_v: got %b want 0", dut_v); end
        n_cmp++; if (dut_done !== 1'b1)  begin n_bad++; $display("FAIL full_done_hold: got %b want 1", dut_done); end
        lb_q.push_back(32'h0000_0005);
        repeat (3) @(negedge clk);
        n_cmp++; if (dut_err !== 1'b1)   begin n_bad++; $display("FAIL extra_hdr_err: got %b want 1", dut_err); end
        n_cmp++; if (dut_recv !== 5'd16) begin n_bad++; $display("FAIL extra_hdr_recv: got %0d want 16", dut_recv); end
    endtask

    task automatic test_corrupt;
        int i;
        do_reset();
        corrupt = 1'b1;
        dut_en  = 1'b1;
        for (i = 0; i < 200; i++) begin
            @(negedge clk);
            if (dut_recv == 5'd2) break;
        end
        n_cmp++; if (i == 200 || dut_err !== 1'b0) begin
            n_bad++; $display("FAIL corrupt_pre_err: got err=%b recv=%0d want err=0 recv=2", dut_err, dut_recv);
        end
        wait_dut_done("corrupt_run");
        n_cmp++; if (dut_err !== 1'b1)   begin n_bad++; $display("FAIL corrupt_err: got %b want 1", dut_err); end
        n_cmp++; if (dut_recv !== 5'd16) begin n_bad++; $display("FAIL corrupt_recv: got %0d want 16", dut_recv); end
        repeat (10) @(negedge clk);
        n_cmp++; if (dut_err !== 1'b1)   begin n_bad++; $display("FAIL corrupt_sticky: got %b want 1", dut_err); end
        corrupt = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_packet();
        test_mid_packet_reset();
        test_backpressure();
        test_en_low();
        test_full_run();
        test_corrupt();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
